// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the controller state encoding, the forwarding-select codes and the
// bundle of per-stage load enables and flushes driven back into the pipeline.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_DRAIN  = 2'd1,
    HZ_HALTED = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic memwb_write;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctl_t;

  // All five load enables set to w, both flushes clear.
  function automatic pipe_ctl_t ctl_writes(input logic w);
    pipe_ctl_t c;
    c.pc_write    = w;
    c.ifid_write  = w;
    c.idex_write  = w;
    c.exmem_write = w;
    c.memwb_write = w;
    c.ifid_flush  = 1'b0;
    c.idex_flush  = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/forward_unit.sv
// EX operand forwarding select: picks register file, MEM/WB or EX/MEM result.
// Latency: purely combinational. Backpressure: none, no state.
// Ports: EX/MEM and MEM/WB rd + RegWrite, ID/EX rs1/rs2 in; fwd_a/fwd_b out.
module forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [REG_AW-1:0] idex_rs1,
  input  logic [REG_AW-1:0] idex_rs2,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // The younger result (EX/MEM) wins when both stages target the same
  // register; x0 is never forwarded since it is hardwired to zero.
  function automatic logic [1:0] pick(input logic [REG_AW-1:0] rs);
    if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs))
      return FWD_MEM;
    else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign fwd_a = pick(idex_rs1);
  assign fwd_b = pick(idex_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: stalls, flushes, forwarding, halt drain.
// Latency: control outputs combinational from state+inputs; state/counters update on clk.
// Backpressure: mem_wait freezes every stage; load-use holds PC and IF/ID for one bubble.
// Ports: buffer-register hazard fields in; load enables, flushes, fwd selects,
// halted and saturating stall/flush counters out. reset is async active-low.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_wait,
  input  logic [REG_AW-1:0] ifid_rs1,
  input  logic [REG_AW-1:0] ifid_rs2,
  input  logic              ifid_halt,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic [REG_AW-1:0] idex_rs1,
  input  logic [REG_AW-1:0] idex_rs2,
  input  logic              ex_pc_sel,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_halt,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              exmem_write,
  output logic              memwb_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  hz_state_e  state, state_nxt;
  pipe_ctl_t  ctl;
  logic       halted_c;
  logic       stall_inc;
  logic       flush_inc;
  logic       load_use;
  logic [1:0] fwd_a_c, fwd_b_c;

  assign load_use = idex_memread && (idex_rd != '0) &&
                    ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  always_comb begin
    ctl       = ctl_writes(1'b0);
    state_nxt = state;
    halted_c  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      HZ_RUN, HZ_DRAIN: begin
        ctl = ctl_writes(1'b1);
        if (mem_wait) begin
          // Freeze everything; a pending branch or load-use stays in place
          // and is acted on once memory is ready.
          ctl       = ctl_writes(1'b0);
          stall_inc = 1'b1;
        end else if (ex_pc_sel) begin
          // ID instruction is squashed, so its load-use or halt is moot.
          ctl.ifid_flush = 1'b1;
          ctl.idex_flush = 1'b1;
          flush_inc      = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID, insert one bubble; the bubble clears
          // idex_memread next cycle, so the stall never repeats.
          ctl.pc_write   = 1'b0;
          ctl.ifid_write = 1'b0;
          ctl.idex_flush = 1'b1;
          stall_inc      = 1'b1;
        end

        if (state == HZ_DRAIN) begin
          // Stop fetching and feed bubbles behind the halt; a memory
          // freeze still takes precedence over the bubble injection.
          ctl.pc_write = 1'b0;
          if (!mem_wait)
            ctl.ifid_flush = 1'b1;
          if (memwb_halt)
            state_nxt = HZ_HALTED;
        end else if (ifid_halt && !mem_wait && !ex_pc_sel && !load_use) begin
          state_nxt = HZ_DRAIN;
        end
      end
      HZ_HALTED: begin
        halted_c = 1'b1;
      end
      default: begin
        state_nxt = HZ_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HZ_RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  forward_unit #(
    .REG_AW (REG_AW)
  ) u_fwd (
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .idex_rs1       (idex_rs1),
    .idex_rs2       (idex_rs2),
    .fwd_a          (fwd_a_c),
    .fwd_b          (fwd_b_c)
  );

  // While reset is low every control output is held inactive.
  assign pc_write    = reset & ctl.pc_write;
  assign ifid_write  = reset & ctl.ifid_write;
  assign idex_write  = reset & ctl.idex_write;
  assign exmem_write = reset & ctl.exmem_write;
  assign memwb_write = reset & ctl.memwb_write;
  assign ifid_flush  = reset & ctl.ifid_flush;
  assign idex_flush  = reset & ctl.idex_flush;
  assign halted      = reset & halted_c;
  assign fwd_a       = reset ? fwd_a_c : FWD_RF;
  assign fwd_b       = reset ? fwd_b_c : FWD_RF;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table plus hand sequences for multi-cycle cases.
// Latency: expected outputs queued at drive time, popped and compared on the falling edge.
// Backpressure: n/a; counters checked one cycle after each stimulus.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              mem_wait, ifid_halt, idex_memread, ex_pc_sel;
  logic              exmem_regwrite, memwb_regwrite, memwb_halt;
  logic [REG_AW-1:0] ifid_rs1, ifid_rs2, idex_rd, idex_rs1, idex_rs2, exmem_rd, memwb_rd;
  logic              pc_write, ifid_write, idex_write, exmem_write, memwb_write;
  logic              ifid_flush, idex_flush, halted;
  logic [1:0]        fwd_a, fwd_b;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mem_wait(mem_wait),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_halt(ifid_halt),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .ex_pc_sel(ex_pc_sel),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_halt(memwb_halt),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .memwb_write(memwb_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc, ifid, idex, exmem, memwb writes, ifid_flush, idex_flush, fwd_a, fwd_b, halted}
  wire [11:0] outs = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                      ifid_flush, idex_flush, fwd_a, fwd_b, halted};

  localparam logic [11:0] O_QUIET = 12'b11111_00_00_00_0;
  localparam logic [11:0] O_LU    = 12'b00111_01_00_00_0;
  localparam logic [11:0] O_BR    = 12'b11111_11_00_00_0;
  localparam logic [11:0] O_MW    = 12'b00000_00_00_00_0;
  localparam logic [11:0] O_DR    = 12'b01111_10_00_00_0;
  localparam logic [11:0] O_DR_LU = 12'b00111_11_00_00_0;
  localparam logic [11:0] O_HALT  = 12'b00000_00_00_00_1;

  typedef struct {
    logic              mem_wait, ifid_halt, idex_memread, ex_pc_sel;
    logic              exmem_regwrite, memwb_regwrite;
    logic [REG_AW-1:0] ifid_rs1, ifid_rs2, idex_rd, idex_rs1, idex_rs2, exmem_rd, memwb_rd;
    logic [11:0]       exp;
    logic              ds, df;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  logic [11:0] exp_q[$];
  int n_err = 0;
  int n_chk = 0;
  logic [CNT_W-1:0] exp_stall, exp_flush;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic idle();
    mem_wait = 0; ifid_halt = 0; idex_memread = 0; ex_pc_sel = 0;
    exmem_regwrite = 0; memwb_regwrite = 0; memwb_halt = 0;
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rd = 0; idex_rs1 = 0; idex_rs2 = 0;
    exmem_rd = 0; memwb_rd = 0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at posedge+1.
  task automatic step(input string nm, input logic [11:0] exp, input logic ds, input logic df);
    logic [11:0] want;
    exp_q.push_back(exp);
    @(negedge clk);
    want = exp_q.pop_front();
    chk({nm, ".outs"}, {20'd0, outs}, {20'd0, want});
    if (ds && exp_stall != '1) exp_stall = exp_stall + 1'b1;
    if (df && exp_flush != '1) exp_flush = exp_flush + 1'b1;
    @(posedge clk); #1;
    chk({nm, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, exp_stall});
    chk({nm, ".flush_cnt"}, {16'd0, flush_cnt}, {16'd0, exp_flush});
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    #7;
    @(posedge clk); #1;
    reset = 1;
    exp_stall = '0;
    exp_flush = '0;
  endtask

  task automatic apply_vec(input int i);
    mem_wait = vecs[i].mem_wait; ifid_halt = vecs[i].ifid_halt;
    idex_memread = vecs[i].idex_memread; ex_pc_sel = vecs[i].ex_pc_sel;
    exmem_regwrite = vecs[i].exmem_regwrite; memwb_regwrite = vecs[i].memwb_regwrite;
    ifid_rs1 = vecs[i].ifid_rs1; ifid_rs2 = vecs[i].ifid_rs2; idex_rd = vecs[i].idex_rd;
    idex_rs1 = vecs[i].idex_rs1; idex_rs2 = vecs[i].idex_rs2;
    exmem_rd = vecs[i].exmem_rd; memwb_rd = vecs[i].memwb_rd; memwb_halt = 0;
    step($sformatf("vec%0d", i), vecs[i].exp, vecs[i].ds, vecs[i].df);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NV; i++) begin
      vecs[i] = '{default: '0};
      vecs[i].exp = O_QUIET;
    end
    // 1: load-use on rs2
    vecs[1].idex_memread = 1; vecs[1].idex_rd = 5; vecs[1].ifid_rs2 = 5;
    vecs[1].exp = O_LU; vecs[1].ds = 1;
    // 2: load to x0 never stalls
    vecs[2].idex_memread = 1; vecs[2].idex_rd = 0; vecs[2].ifid_rs2 = 0;
    // 3: load-use on rs1
    vecs[3].idex_memread = 1; vecs[3].idex_rd = 5; vecs[3].ifid_rs1 = 5; vecs[3].ifid_rs2 = 9;
    vecs[3].exp = O_LU; vecs[3].ds = 1;
    // 4: both stages match rs1, EX/MEM wins
    vecs[4].exmem_regwrite = 1; vecs[4].exmem_rd = 7; vecs[4].memwb_regwrite = 1;
    vecs[4].memwb_rd = 7; vecs[4].idex_rs1 = 7; vecs[4].exp = 12'b11111_00_10_00_0;
    // 5: EX/MEM not writing, MEM/WB forwards
    vecs[5] = vecs[4]; vecs[5].exmem_regwrite = 0; vecs[5].exp = 12'b11111_00_01_00_0;
    // 6: x0 never forwarded
    vecs[6].exmem_regwrite = 1; vecs[6].memwb_regwrite = 1;
    // 7: independent selects for A and B
    vecs[7].exmem_regwrite = 1; vecs[7].exmem_rd = 4; vecs[7].idex_rs1 = 4;
    vecs[7].memwb_regwrite = 1; vecs[7].memwb_rd = 3; vecs[7].idex_rs2 = 3;
    vecs[7].exp = 12'b11111_00_10_01_0;
    // 8: branch beats load-use and halt
    vecs[8].ex_pc_sel = 1; vecs[8].ifid_halt = 1; vecs[8].idex_memread = 1;
    vecs[8].idex_rd = 5; vecs[8].ifid_rs1 = 5; vecs[8].exp = O_BR; vecs[8].df = 1;
    // 9: quiet again, proves halt was squashed (still RUN)
    // 10: memory freeze
    vecs[10].mem_wait = 1; vecs[10].exp = O_MW; vecs[10].ds = 1;
    // 11: freeze plus load-use counts once
    vecs[11].mem_wait = 1; vecs[11].idex_memread = 1; vecs[11].idex_rd = 6;
    vecs[11].ifid_rs2 = 6; vecs[11].exp = O_MW; vecs[11].ds = 1;

    // Reset held low with random inputs
    idle();
    exp_stall = '0; exp_flush = '0;
    for (int i = 0; i < 5; i++) begin
      {mem_wait, ifid_halt, idex_memread, ex_pc_sel} = 4'($urandom);
      {exmem_regwrite, memwb_regwrite, memwb_halt} = 3'($urandom);
      {ifid_rs1, ifid_rs2, idex_rd, idex_rs1} = 20'($urandom);
      {idex_rs2, exmem_rd, memwb_rd} = 15'($urandom);
      #3;
      chk("reset.outs", {20'd0, outs}, 32'd0);
      chk("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("reset.flush_cnt", {16'd0, flush_cnt}, 32'd0);
    end
    idle();
    @(posedge clk); #1;
    reset = 1;
    step("release", O_QUIET, 0, 0);

    for (int i = 0; i < NV; i++) apply_vec(i);

    // mem_wait holds a pending branch for three cycles
    do_reset();
    mem_wait = 1; ex_pc_sel = 1;
    step("mw1", O_MW, 1, 0);
    step("mw2", O_MW, 1, 0);
    step("mw3", O_MW, 1, 0);
    mem_wait = 0;
    step("mw_drop", O_BR, 0, 1);
    ex_pc_sel = 0;
    step("mw_after", O_QUIET, 0, 0);

    // Halt drain to HALTED
    do_reset();
    ifid_halt = 1;
    step("halt_enter", O_QUIET, 0, 0);
    ifid_halt = 0;
    step("drain1", O_DR, 0, 0);
    step("drain2", O_DR, 0, 0);
    memwb_halt = 1;
    step("drain3", O_DR, 0, 0);
    memwb_halt = 0;
    step("halted", O_HALT, 0, 0);
    mem_wait = 1; ex_pc_sel = 1; exmem_regwrite = 1; exmem_rd = 2; idex_rs1 = 2;
    step("halted_frozen", 12'b00000_00_10_00_1, 0, 0);

    // Load-use inside DRAIN, then reset mid-drain
    do_reset();
    ifid_halt = 1;
    step("halt2_enter", O_QUIET, 0, 0);
    ifid_halt = 0; idex_memread = 1; idex_rd = 5; ifid_rs1 = 5;
    step("drain_lu", O_DR_LU, 1, 0);
    idle();
    step("drain_q", O_DR, 0, 0);
    #2 reset = 0;
    #1;
    chk("mid_reset.outs", {20'd0, outs}, 32'd0);
    chk("mid_reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    exp_stall = '0; exp_flush = '0;
    @(posedge clk); #1;
    reset = 1;
    step("after_reset_run", O_QUIET, 0, 0);

    // Stall counter saturation
    do_reset();
    mem_wait = 1;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat.stall_full", {16'd0, stall_cnt}, 32'h0000_FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat.stall_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
    chk("sat.flush_zero", {16'd0, flush_cnt}, 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Backward-flowing control for the 5-stage RISC-V pipeline.
- Reads hazard-relevant fields that the stages write into the IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers.
- Drives the write-enable, flush and forwarding-select signals back into those registers and the EX operand muxes.
- Owns the halt-drain state machine and saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- mem_wait  in  1  data memory not ready; freeze the whole pipeline.
- ifid_rs1  in  REG_AW  rs1 of the instruction in ID.
- ifid_rs2  in  REG_AW  rs2 of the instruction in ID.
- ifid_halt  in  1  halt bit of the IF/ID register.
- idex_memread  in  1  ID/EX MemRead.
- idex_rd  in  REG_AW  ID/EX rd.
- idex_rs1  in  REG_AW  ID/EX RS_One.
- idex_rs2  in  REG_AW  ID/EX RS_Two.
- ex_pc_sel  in  1  branch/jump taken, resolved in EX.
- exmem_regwrite  in  1  EX/MEM RegWrite.
- exmem_rd  in  REG_AW  EX/MEM rd.
- memwb_regwrite  in  1  MEM/WB RegWrite.
- memwb_rd  in  REG_AW  MEM/WB rd.
- memwb_halt  in  1  halt bit of the MEM/WB register.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- idex_write  out  1  ID/EX load enable.
- exmem_write  out  1  EX/MEM load enable.
- memwb_write  out  1  MEM/WB load enable.
- ifid_flush  out  1  clear IF/ID to a bubble on the next edge.
- idex_flush  out  1  clear ID/EX to a bubble on the next edge.
- fwd_a  out  2  EX operand-A select: 00 register file, 01 MEM/WB, 10 EX/MEM.
- fwd_b  out  2  EX operand-B select, same encoding.
- halted  out  1  pipeline fully drained after halt.
- stall_cnt  out  CNT_W  stall cycles.
- flush_cnt  out  CNT_W  taken-branch flushes.

Behaviour:
- Reset (reset=0, async):
  - State goes to RUN; counters cleared to 0.
  - All outputs are forced inactive while reset is low: write enables 0, flushes 0, fwd_a/fwd_b 00, halted 0.
  - After release, RUN defaults apply from the first edge.
- Control outputs are combinational from state and inputs. The state and counters are registered.
- States:
  - RUN: normal operation.
  - DRAIN: halt is in flight; no new fetch.
  - HALTED: terminal until reset.
- RUN default: all writes 1, flushes 0.
- Priority inside RUN and DRAIN, highest first:
  1. mem_wait=1: all five writes 0, flushes 0. A branch or load-use pending in EX/ID is held and acted on in the cycle mem_wait drops. stall_cnt +1.
  2. ex_pc_sel=1: ifid_flush=1, idex_flush=1, pc_write=1 (target loaded). flush_cnt +1. Load-use and ifid_halt are ignored this cycle, because the ID instruction is squashed.
  3. Load-use: idex_memread=1, idex_rd!=0, and idex_rd equals ifid_rs1 or ifid_rs2.
     - Response: pc_write=0, ifid_write=0, idex_flush=1.
     - Exactly one bubble per load; stall_cnt +1.
- Halt transitions:
  - RUN -> DRAIN: on an edge where ifid_halt=1, mem_wait=0, ex_pc_sel=0 and no load-use. The halt instruction itself advances into ID/EX on that edge.
  - DRAIN: pc_write=0 and ifid_flush=1 every cycle (bubbles fed behind the halt). Other writes follow the priority rules.
  - DRAIN -> HALTED: on the edge where memwb_halt=1.
  - If ifid_halt and ex_pc_sel coincide, the halt is squashed and the state stays RUN.
- HALTED: all writes 0, flushes 0, halted=1, counters frozen. Forwarding outputs still computed.
- Forwarding (combinational, independent of state):
  - fwd_a=10 if exmem_regwrite, exmem_rd!=0 and exmem_rd==idex_rs1.
  - Otherwise fwd_a=01 if memwb_regwrite, memwb_rd!=0 and memwb_rd==idex_rs1.
  - Otherwise fwd_a=00.
  - fwd_b uses the same rules with idex_rs2. EX/MEM wins when both match.
- Counters saturate at all-ones and never wrap. mem_wait and load-use in the same cycle count 1.

Decomposition:
- Package hazard_pkg holds:
  - enum hz_state_e {HZ_RUN, HZ_DRAIN, HZ_HALTED}.
  - localparams FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - struct pipe_ctl_t bundling the five writes and two flushes.
- One sub-module, forward_unit (purely combinational), instantiated once and producing fwd_a/fwd_b.

Test Plan:
- Reset held low with random inputs: all outputs inactive and counters 0. On release with quiet inputs: all writes 1, flushes 0.
- Load-use: idex_memread=1, idex_rd=5, ifid_rs2=5 for one cycle -> pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1. Same with idex_rd=0 -> no stall.
- Branch: ex_pc_sel=1 with a concurrent load-use and ifid_halt=1 -> both flushes 1, pc_write=1, state stays RUN, flush_cnt=1.
- mem_wait=1 for 3 cycles with ex_pc_sel=1 -> all writes 0, no flush, stall_cnt=3. In the cycle mem_wait drops, flushes assert once and flush_cnt=1.
- Halt: ifid_halt=1 -> DRAIN with pc_write=0 and ifid_flush=1. Three cycles later memwb_halt=1 -> halted=1, all writes 0. Assert reset mid-DRAIN -> back to RUN.
- Forwarding: exmem_rd=memwb_rd=7, both regwrite, idex_rs1=7 -> fwd_a=10. With exmem_regwrite=0 -> 01. With rd=0 -> 00. Counter preloaded via 65535 stalls -> stays 0xFFFF.
